// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pipe_pkg
// Shared definitions for the EX/MEM pipeline register slice.
//   - default data-path and register-index widths
//   - bit positions of the M control field {Branch, MemWrite, MemRead}
//   - ex_mem_t: the EX/MEM payload at the default widths, for use by
//     neighbouring stages and by verification code.
package ex_mem_pipe_pkg;

  localparam int EX_MEM_XLEN = 64;
  localparam int EX_MEM_RA_W = 5;

  localparam int M_READ_BIT   = 0;
  localparam int M_WRITE_BIT  = 1;
  localparam int M_BRANCH_BIT = 2;

  typedef struct packed {
    logic [1:0]             wb;
    logic [2:0]             m;
    logic [EX_MEM_XLEN-1:0] adder;
    logic                   zero;
    logic [EX_MEM_XLEN-1:0] alu;
    logic [EX_MEM_XLEN-1:0] store;
    logic [EX_MEM_RA_W-1:0] rd;
  } ex_mem_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf
// Two-entry valid/ready register slice: a main entry that drives the output
// and one skid entry that absorbs the beat arriving while the output stalls.
// i_ready/o_ready are never combinationally linked, so the slice breaks both
// the forward and the backward timing paths.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (overrides flush)
//   flush    in   discard held entries and the beat offered this cycle
//   i_valid  in   upstream beat valid
//   i_data   in   upstream payload, W bits
//   o_ready  out  registered; high while the skid entry is empty
//   o_valid  out  main entry valid
//   o_data   out  main entry payload
//   i_ready  in   downstream accepts
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_main_valid;
  logic         r_skid_valid;
  logic         r_in_ready;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;

  logic w_accept;
  logic w_drain;
  logic w_main_load;
  logic w_skid_to_main;
  logic w_in_to_main;
  logic w_in_to_skid;
  logic w_main_valid_nxt;
  logic w_skid_valid_nxt;

  always_comb begin
    w_accept       = i_valid && r_in_ready;
    w_drain        = r_main_valid && i_ready;
    w_main_load    = !r_main_valid || w_drain;
    // The skid entry is older than anything on the input, so it wins main.
    w_skid_to_main = w_main_load && r_skid_valid;
    w_in_to_main   = w_main_load && !r_skid_valid && w_accept;
    w_in_to_skid   = w_accept && !w_in_to_main;

    w_main_valid_nxt = w_main_load ? (r_skid_valid || w_accept) : r_main_valid;
    w_skid_valid_nxt = w_in_to_skid || (r_skid_valid && !w_skid_to_main);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      // Payload registers keep their contents; only the valid bits drop.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_skid_to_main) begin
        r_main_data <= r_skid_data;
      end else if (w_in_to_main) begin
        r_main_data <= i_data;
      end
      if (w_in_to_skid) begin
        r_skid_data <= i_data;
      end
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_main_valid;
  assign o_data  = r_main_data;

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe
// EX/MEM pipeline register with valid/ready flow control and flush.
// Packs the EX-stage outputs into one payload word, buffers it in a
// pipe_skid_buf, and unpacks it for the MEM stage. Control outputs are forced
// to zero whenever the stage holds no valid entry, so a bubble never writes
// memory, the register file, or redirects the PC.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   WB, M, Adder_Result, ALU_Zero,
//   ALU_Result, Store_Data, rd    EX-stage payload; M = {Branch, MemWrite, MemRead}
//   in_valid / in_ready           upstream handshake (in_ready registered)
//   flush                         drop held entries and the one offered now
//   out_ready / out_valid         downstream handshake
//   WB_Out, Branch, MemWrite,
//   MemRead                       control outputs, zero while out_valid=0
//   Adder_Result_Out, ALU_Zero_Out,
//   ALU_Result_Out, Store_Data_Out,
//   rd_out                        data outputs straight from the main entry
//   PCSrc                         Branch & ALU_Zero_Out & out_valid
//
// Build option EX_MEM_PIPE_PERF_EN adds saturating counters:
//   stall_cnt  cycles with out_valid && !out_ready
//   flush_cnt  cycles with flush while an entry is held
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int XLEN = EX_MEM_XLEN,
  parameter int RA_W = EX_MEM_RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      WB,
  input  logic [2:0]      M,
  input  logic [XLEN-1:0] Adder_Result,
  input  logic            ALU_Zero,
  input  logic [XLEN-1:0] ALU_Result,
  input  logic [XLEN-1:0] Store_Data,
  input  logic [RA_W-1:0] rd,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [1:0]      WB_Out,
  output logic            Branch,
  output logic            MemWrite,
  output logic            MemRead,
  output logic [XLEN-1:0] Adder_Result_Out,
  output logic [XLEN-1:0] ALU_Result_Out,
  output logic [XLEN-1:0] Store_Data_Out,
  output logic            ALU_Zero_Out,
  output logic [RA_W-1:0] rd_out,
  output logic            PCSrc
`ifdef EX_MEM_PIPE_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  // Same field layout as ex_mem_t, sized by this instance's parameters.
  typedef struct packed {
    logic [1:0]      wb;
    logic [2:0]      m;
    logic [XLEN-1:0] adder;
    logic            zero;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] store;
    logic [RA_W-1:0] rd;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t w_in_pl;
  payload_t w_out_pl;
  logic     w_out_valid;

  always_comb begin
    w_in_pl       = '0;
    w_in_pl.wb    = WB;
    w_in_pl.m     = M;
    w_in_pl.adder = Adder_Result;
    w_in_pl.zero  = ALU_Zero;
    w_in_pl.alu   = ALU_Result;
    w_in_pl.store = Store_Data;
    w_in_pl.rd    = rd;
  end

  pipe_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (in_valid),
    .i_data  (w_in_pl),
    .o_ready (in_ready),
    .o_valid (w_out_valid),
    .o_data  (w_out_pl),
    .i_ready (out_ready)
  );

  assign out_valid = w_out_valid;

  // Bubble masking: controls read zero whenever nothing valid is held.
  assign WB_Out   = w_out_valid ? w_out_pl.wb : 2'b00;
  assign Branch   = w_out_valid & w_out_pl.m[M_BRANCH_BIT];
  assign MemWrite = w_out_valid & w_out_pl.m[M_WRITE_BIT];
  assign MemRead  = w_out_valid & w_out_pl.m[M_READ_BIT];

  assign Adder_Result_Out = w_out_pl.adder;
  assign ALU_Zero_Out     = w_out_pl.zero;
  assign ALU_Result_Out   = w_out_pl.alu;
  assign Store_Data_Out   = w_out_pl.store;
  assign rd_out           = w_out_pl.rd;

  assign PCSrc = Branch & ALU_Zero_Out & w_out_valid;

`ifdef EX_MEM_PIPE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // The skid entry is only ever occupied behind a valid main entry, so the
  // main valid bit alone tells whether anything is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (flush && w_out_valid && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
